// File: rtl/tweet_pkg.sv
// Shared definitions for the tweetboard buffer controller: FSM encoding,
// terminator byte and default buffer depth.
package tweet_pkg;

    localparam int DEFAULT_DEPTH = 140;
    localparam logic [7:0] LF_BYTE = 8'h0A;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_ACK   = 3'd3,
        S_DRAIN = 3'd4,
        S_TERM  = 3'd5
    } state_t;

endpackage

// File: rtl/tweet_buf_ram.sv
// Single-port DEPTH x 8 message RAM with a one-cycle synchronous read.
module tweet_buf_ram #(
    parameter int DEPTH = 140,
    parameter int AW    = 8
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [7:0]    din_i,
    output logic [7:0]    dout_o
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i[IW-1:0]] <= din_i;
        end
        dout_o <= mem_q[addr_i[IW-1:0]];
    end

endmodule

// File: rtl/tweet_buf_ctrl.sv
// Collects UART RX bytes into a linear buffer and, on a button press, replays
// them to the UART TX one byte at a time (optionally LF-terminated), then empties.
module tweet_buf_ctrl
    import tweet_pkg::*;
#(
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int AW        = 8,
    parameter int APPEND_LF = 1
) (
    input  logic          sysclk,
    input  logic          reset,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    input  logic          btn_write,
    input  logic          tx_busy,
    output logic          tx_start,
    output logic [7:0]    tx_data,
    output logic [AW-1:0] count,
    output logic          busy,
    output logic          overflow,
    output state_t        state_dbg
);

    localparam logic [AW-1:0] DEPTH_C = AW'(DEPTH);

    state_t        state_q, state_d;
    logic [AW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic          ovf_q, ovf_d;
    logic          tx_start_q, tx_start_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          lf_sent_q, lf_sent_d;
    logic          btn_q;

    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_dout;
    logic          btn_rise;
    logic [AW-1:0] rd_next;

    tweet_buf_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i  (sysclk),
        .we_i   (ram_we),
        .addr_i (ram_addr),
        .din_i  (rx_data),
        .dout_o (ram_dout)
    );

    assign btn_rise = btn_write & ~btn_q;
    assign rd_next  = rd_ptr_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        ovf_d      = ovf_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        lf_sent_d  = lf_sent_q;
        ram_we     = 1'b0;
        ram_addr   = rd_ptr_q;

        // The buffer is owned by playback until it finishes: incoming bytes are lost.
        if (state_q != S_IDLE && rx_valid) begin
            ovf_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                ram_addr  = count_q;
                lf_sent_d = 1'b0;
                if (rx_valid) begin
                    if (count_q < DEPTH_C) begin
                        ram_we  = 1'b1;
                        count_d = count_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                // count_d includes a byte stored in this same cycle.
                if (btn_rise && count_d != '0) begin
                    rd_ptr_d = '0;
                    state_d  = S_FETCH;
                end
            end
            S_FETCH: state_d = S_ISSUE;
            S_ISSUE: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = ram_dout;
                    state_d    = S_ACK;
                end
            end
            S_ACK: begin
                if (tx_busy) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!tx_busy) begin
                    if (!lf_sent_q && rd_next < count_q) begin
                        rd_ptr_d = rd_next;
                        state_d  = S_FETCH;
                    end else if (!lf_sent_q && APPEND_LF != 0) begin
                        state_d = S_TERM;
                    end else begin
                        count_d = '0;
                        ovf_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            S_TERM: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = LF_BYTE;
                    lf_sent_d  = 1'b1;
                    state_d    = S_ACK;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        btn_q <= btn_write;
        if (!reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            ovf_q      <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            lf_sent_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            ovf_q      <= ovf_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            lf_sent_q  <= lf_sent_d;
        end
    end

    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign count     = count_q;
    assign busy      = (state_q != S_IDLE);
    assign overflow  = ovf_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_tweet_buf_ctrl.sv
// Bench for tweet_buf_ctrl: a small transmitter model answers tx_start, and a
// scoreboard queue holds the bytes the transmitter is expected to receive.
module tb_tweet_buf_ctrl;
    import tweet_pkg::*;

    localparam int DEPTH    = 4;
    localparam int AW       = 8;
    localparam int BYTE_CYC = 6;

    logic          sysclk = 1'b0;
    logic          reset;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          btn_write;
    logic          tx_busy = 1'b0;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic [AW-1:0] count;
    logic          busy;
    logic          overflow;
    state_t        state_dbg;

    int         checks   = 0;
    int         errors   = 0;
    int         n_starts = 0;
    int         tx_cnt   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_tx  = 8'h00;
    bit         track    = 1'b0;

    int m_count   = 0;
    bit m_ovf     = 1'b0;
    bit m_playing = 1'b0;

    always #10 sysclk = ~sysclk;

    tweet_buf_ctrl #(
        .DEPTH     (DEPTH),
        .AW        (AW),
        .APPEND_LF (1)
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .btn_write (btn_write),
        .tx_busy   (tx_busy),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .count     (count),
        .busy      (busy),
        .overflow  (overflow),
        .state_dbg (state_dbg)
    );

    // Transmitter: busy from the cycle after tx_start for BYTE_CYC cycles.
    always @(posedge sysclk) begin
        if (tx_cnt > 0) begin
            tx_cnt <= tx_cnt - 1;
            if (tx_cnt == 1) tx_busy <= 1'b0;
        end else if (tx_start === 1'b1) begin
            tx_busy <= 1'b1;
            tx_cnt  <= BYTE_CYC;
        end
    end

    // Scoreboard: every tx_start consumes the oldest expected byte.
    always @(negedge sysclk) begin
        logic [7:0] exp_b;
        if (tx_start === 1'b1) begin
            n_starts++;
            checks++;
            if (tx_busy !== 1'b0) begin
                errors++;
                $display("FAIL start_while_busy: tx_busy=%b required 0", tx_busy);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_start: tx_data=%h with no byte expected", tx_data);
            end else begin
                exp_b = exp_q.pop_front();
                if (tx_data !== exp_b) begin
                    errors++;
                    $display("FAIL tx_byte: got %h required %h", tx_data, exp_b);
                end
            end
            last_tx = tx_data;
            track   = 1'b1;
        end else if (tx_busy && track && reset === 1'b1) begin
            checks++;
            if (tx_data !== last_tx) begin
                errors++;
                $display("FAIL tx_data_stable: got %h required %h", tx_data, last_tx);
            end
        end
        if (reset === 1'b0) track = 1'b0;
    end

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic model_press();
        if (!m_playing && m_count > 0) begin
            exp_q.push_back(8'h0A);
            m_playing = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit with_btn);
        rx_valid  = 1'b1;
        rx_data   = b;
        btn_write = with_btn;
        if (!m_playing && m_count < DEPTH) begin
            exp_q.push_back(b);
            m_count++;
        end else begin
            m_ovf = 1'b1;
        end
        if (with_btn) model_press();
        tick();
        rx_valid  = 1'b0;
        btn_write = 1'b0;
        tick();
    endtask

    task automatic press();
        btn_write = 1'b1;
        model_press();
        tick();
        btn_write = 1'b0;
        tick();
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400; i++) begin
            @(negedge sysclk);
            if (busy === 1'b0) break;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL playback_timeout: busy=%b required 0", busy);
        end
        m_count   = 0;
        m_ovf     = 1'b0;
        m_playing = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        btn_write = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        repeat (5) tick();
        @(negedge sysclk);
        checks += 5;
        if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d required 0", count); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b required 0", overflow); end
        if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h required 00", tx_data); end
        if (state_dbg !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d required %0d", state_dbg, S_IDLE); end
        reset = 1'b1;
        repeat (10) @(negedge sysclk);
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL held_button_busy: got %b required 0", busy); end
        if (n_starts !== 0) begin errors++; $display("FAIL held_button_starts: got %0d required 0", n_starts); end
        btn_write = 1'b0;
        tick();
    endtask

    task automatic test_collect_play();
        int base = n_starts;
        send_byte(8'h55, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'h55, 1'b0);
        @(negedge sysclk);
        checks += 2;
        if (count !== AW'(3)) begin errors++; $display("FAIL collect_count: got %0d required 3", count); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL collect_overflow: got %b required 0", overflow); end
        tick();
        press();
        @(negedge sysclk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL play_busy: got %b required 1", busy); end
        wait_done();
        @(negedge sysclk);
        checks += 3;
        if (count !== '0) begin errors++; $display("FAIL play_count_after: got %0d required 0", count); end
        if (n_starts - base !== 4) begin errors++; $display("FAIL play_starts: got %0d required 4", n_starts - base); end
        if (exp_q.size() !== 0) begin errors++; $display("FAIL play_leftover: got %0d required 0", exp_q.size()); end
        tick();
    endtask

    task automatic test_overflow();
        int base = n_starts;
        for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b0);
        @(negedge sysclk);
        checks += 2;
        if (count !== AW'(DEPTH)) begin errors++; $display("FAIL ovf_count: got %0d required %0d", count, DEPTH); end
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b required 1", overflow); end
        tick();
        press();
        wait_done();
        @(negedge sysclk);
        checks += 3;
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_cleared: got %b required 0", overflow); end
        if (count !== '0) begin errors++; $display("FAIL ovf_count_after: got %0d required 0", count); end
        if (n_starts - base !== 5) begin errors++; $display("FAIL ovf_starts: got %0d required 5", n_starts - base); end
        tick();
    endtask

    task automatic test_empty_press();
        int base = n_starts;
        press();
        repeat (10) @(negedge sysclk);
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL empty_busy: got %b required 0", busy); end
        if (n_starts !== base) begin errors++; $display("FAIL empty_starts: got %0d required %0d", n_starts, base); end
        tick();
    endtask

    task automatic test_rx_during_play();
        int base = n_starts;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        press();
        send_byte(8'h08, 1'b0);
        @(negedge sysclk);
        checks += 3;
        if (count !== AW'(2)) begin errors++; $display("FAIL rxplay_count: got %0d required 2", count); end
        if (overflow !== 1'b1) begin errors++; $display("FAIL rxplay_overflow: got %b required 1", overflow); end
        if (busy !== 1'b1) begin errors++; $display("FAIL rxplay_busy: got %b required 1", busy); end
        wait_done();
        @(negedge sysclk);
        checks++;
        if (n_starts - base !== 3) begin errors++; $display("FAIL rxplay_starts: got %0d required 3", n_starts - base); end
        tick();
    endtask

    task automatic test_same_cycle();
        int base = n_starts;
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b1);
        @(negedge sysclk);
        checks += 2;
        if (busy !== 1'b1) begin errors++; $display("FAIL same_busy: got %b required 1", busy); end
        if (count !== AW'(2)) begin errors++; $display("FAIL same_count: got %0d required 2", count); end
        wait_done();
        @(negedge sysclk);
        checks++;
        if (n_starts - base !== 3) begin errors++; $display("FAIL same_starts: got %0d required 3", n_starts - base); end
        tick();
    endtask

    task automatic test_reset_mid();
        int base = n_starts;
        int seen;
        for (int i = 0; i < 5; i++) send_byte(8'(8'hC0 + i), 1'b0);
        press();
        for (int i = 0; i < 200; i++) begin
            @(negedge sysclk);
            if (n_starts - base >= 2) break;
        end
        checks++;
        if (n_starts - base < 2) begin
            errors++;
            $display("FAIL midreset_reach: got %0d starts required 2", n_starts - base);
        end
        reset = 1'b0;
        exp_q.delete();
        m_count   = 0;
        m_ovf     = 1'b0;
        m_playing = 1'b0;
        @(negedge sysclk);
        checks += 4;
        if (count !== '0) begin errors++; $display("FAIL midreset_count: got %0d required 0", count); end
        if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b required 0", busy); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL midreset_overflow: got %b required 0", overflow); end
        if (tx_start !== 1'b0) begin errors++; $display("FAIL midreset_start: got %b required 0", tx_start); end
        reset = 1'b1;
        seen  = n_starts;
        repeat (60) @(negedge sysclk);
        checks += 2;
        if (n_starts !== seen) begin errors++; $display("FAIL midreset_no_more: got %0d starts required %0d", n_starts, seen); end
        if (busy !== 1'b0) begin errors++; $display("FAIL midreset_idle: got %b required 0", busy); end
        tick();
    endtask

    initial begin
        test_reset();
        test_collect_play();
        test_overflow();
        test_empty_press();
        test_rx_during_play();
        test_same_cycle();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
